// File: rtl/bcd_seg7_display.sv
// bcd_seg7_display: sequential binary-to-BCD converter driving 7-segment displays.
// Uses iterative double-dabble, one add-3/shift step per clock.
// The converted digits, overflow flag and segment patterns are registered.
// They update only on the final shift edge and hold until the next result.
// Optional feature: define BCD_SEG7_BLANK_ZERO_EN for leading-zero blanking.
// Segment bit order per digit is {g,f,e,d,c,b,a}.
module bcd_seg7_display #(
    parameter int WIDTH          = 16,
    parameter int DIGITS         = 5,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [SW-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SW{1'b1}} : {SW{1'b0}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] operand_shifted;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adjusted;
    logic [BW-1:0]   scratch_shifted;
    logic            scratch_ovf;
    logic            ovf_next;
    logic [CW-1:0]   count;
    logic            last_shift;
    logic [SW-1:0]   seg_next;
    logic [3:0]      digit;
    logic [6:0]      pattern;
`ifdef BCD_SEG7_BLANK_ZERO_EN
    logic            higher_nz;
`endif

    // Active-high pattern for one BCD digit; impossible codes 10..15 show blank.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: accept load only when idle, return after WIDTH shifts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy during shifting, flag the edge that completes the result.
    always_comb begin
        busy       = (state == SHIFT);
        last_shift = (state == SHIFT) && (count == LAST_COUNT);
    end

    // One double-dabble step: add 3 to digits >= 5, then shift scratch:operand left.
    always_comb begin
        adjusted = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
        scratch_shifted = {adjusted[BW-2:0], operand[WIDTH-1]};
        operand_shifted = operand << 1;
        ovf_next        = scratch_ovf | adjusted[BW-1];
    end

    // Segment patterns for the result about to be registered (dashes on overflow).
    always_comb begin
        seg_next = '0;
        digit    = '0;
        pattern  = '0;
`ifdef BCD_SEG7_BLANK_ZERO_EN
        higher_nz = 1'b0;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            digit   = scratch_shifted[4*k +: 4];
            pattern = decode(digit);
            if (ovf_next) pattern = 7'h40;
`ifdef BCD_SEG7_BLANK_ZERO_EN
            else if ((k != 0) && !higher_nz && (digit == 4'd0)) pattern = 7'h00;
            if (digit != 4'd0) higher_nz = 1'b1;
`endif
            seg_next[7*k +: 7] = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
        end
    end

    // Conversion datapath: latch operand on accept, step once per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand     <= '0;
            scratch     <= '0;
            scratch_ovf <= 1'b0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        operand     <= value;
                        scratch     <= '0;
                        scratch_ovf <= 1'b0;
                        count       <= '0;
                    end
                end
                SHIFT: begin
                    operand     <= operand_shifted;
                    scratch     <= scratch_shifted;
                    scratch_ovf <= ovf_next;
                    count       <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: update only on the final shift edge, pulse done after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            seg      <= SEG_OFF;
        end else begin
            done <= last_shift;
            if (last_shift) begin
                bcd      <= scratch_shifted;
                overflow <= ovf_next;
                seg      <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg7_display.sv
// tb_bcd_seg7_display: directed self-checking bench for bcd_seg7_display.
// Three instances: defaults, DIGITS=4 (overflow cases) and SEG_ACTIVE_LOW=1.
// Expected segment values follow BCD_SEG7_BLANK_ZERO_EN when it is defined.
module tb_bcd_seg7_display;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
    localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S9 = 7'h6F;
    localparam logic [6:0] DASH = 7'h40, BL = 7'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        load0 = 1'b0, load4 = 1'b0, load_al = 1'b0;
    logic [15:0] val0 = '0, val4 = '0, val_al = '0;
    logic        busy0, busy4, busy_al;
    logic        done0, done4, done_al;
    logic        ovf0, ovf4, ovf_al;
    logic [19:0] bcd0, bcd_al;
    logic [15:0] bcd4;
    logic [34:0] seg0, seg_al;
    logic [27:0] seg4;

    int n_cmp = 0;
    int n_fail = 0;

    bcd_seg7_display #(.WIDTH(16), .DIGITS(5), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load0), .value(val0), .busy(busy0),
        .done(done0), .overflow(ovf0), .bcd(bcd0), .seg(seg0)
    );

    bcd_seg7_display #(.WIDTH(16), .DIGITS(4), .SEG_ACTIVE_LOW(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load4), .value(val4), .busy(busy4),
        .done(done4), .overflow(ovf4), .bcd(bcd4), .seg(seg4)
    );

    bcd_seg7_display #(.WIDTH(16), .DIGITS(5), .SEG_ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .load(load_al), .value(val_al), .busy(busy_al),
        .done(done_al), .overflow(ovf_al), .bcd(bcd_al), .seg(seg_al)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy4;
            default: return busy_al;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done0;
            1:       return done4;
            default: return done_al;
        endcase
    endfunction

    // Pulse load on one instance and wait (bounded) for its done cycle.
    task automatic convert(input int sel, input logic [15:0] v, output int busy_cnt, output bit ok);
        @(negedge clk);
        case (sel)
            0:       begin load0 = 1'b1;   val0 = v;   end
            1:       begin load4 = 1'b1;   val4 = v;   end
            default: begin load_al = 1'b1; val_al = v; end
        endcase
        @(negedge clk);
        load0 = 1'b0; load4 = 1'b0; load_al = 1'b0;
        busy_cnt = 0;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (get_done(sel)) begin
                ok = 1'b1;
                break;
            end
            if (get_busy(sel)) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", ovf0); end
        n_cmp++; if (bcd0 !== 20'h0) begin n_fail++; $display("[TB] FAIL reset_bcd: got %h expected 00000", bcd0); end
        n_cmp++; if (seg0 !== 35'h0) begin n_fail++; $display("[TB] FAIL reset_seg: got %h expected 0", seg0); end
        n_cmp++; if (seg_al !== {35{1'b1}}) begin n_fail++; $display("[TB] FAIL reset_seg_al: got %h expected 7ffffffff", seg_al); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_1234();
        int bc; bit ok;
        logic [34:0] exp_seg;
`ifdef BCD_SEG7_BLANK_ZERO_EN
        exp_seg = {BL, S1, S2, S3, S4};
`else
        exp_seg = {S0, S1, S2, S3, S4};
`endif
        convert(0, 16'd1234, bc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL 1234_done_seen: got %b expected 1", ok); end
        n_cmp++; if (bc != 16) begin n_fail++; $display("[TB] FAIL 1234_busy_cycles: got %0d expected 16", bc); end
        n_cmp++; if (bcd0 !== 20'h01234) begin n_fail++; $display("[TB] FAIL 1234_bcd: got %h expected 01234", bcd0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("[TB] FAIL 1234_overflow: got %b expected 0", ovf0); end
        n_cmp++; if (seg0 !== exp_seg) begin n_fail++; $display("[TB] FAIL 1234_seg: got %h expected %h", seg0, exp_seg); end
        @(negedge clk);
        n_cmp++; if (done0 !== 1'b0) begin n_fail++; $display("[TB] FAIL 1234_done_width: got %b expected 0", done0); end
    endtask

    task automatic test_max();
        int bc; bit ok;
        convert(0, 16'hFFFF, bc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL max_done_seen: got %b expected 1", ok); end
        n_cmp++; if (bcd0 !== 20'h65535) begin n_fail++; $display("[TB] FAIL max_bcd: got %h expected 65535", bcd0); end
        n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("[TB] FAIL max_overflow: got %b expected 0", ovf0); end
        n_cmp++; if (seg0 !== {S6, S5, S5, S3, S5}) begin n_fail++; $display("[TB] FAIL max_seg: got %h expected %h", seg0, {S6, S5, S5, S3, S5}); end
    endtask

    task automatic test_zero();
        int bc; bit ok;
        logic [34:0] exp_seg;
`ifdef BCD_SEG7_BLANK_ZERO_EN
        exp_seg = {BL, BL, BL, BL, S0};
`else
        exp_seg = {S0, S0, S0, S0, S0};
`endif
        convert(0, 16'd0, bc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_done_seen: got %b expected 1", ok); end
        n_cmp++; if (bcd0 !== 20'h0) begin n_fail++; $display("[TB] FAIL zero_bcd: got %h expected 00000", bcd0); end
        n_cmp++; if (seg0 !== exp_seg) begin n_fail++; $display("[TB] FAIL zero_seg: got %h expected %h", seg0, exp_seg); end
    endtask

    task automatic test_overflow();
        int bc; bit ok;
        convert(1, 16'd12345, bc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_done_seen: got %b expected 1", ok); end
        n_cmp++; if (ovf4 !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_12345_flag: got %b expected 1", ovf4); end
        n_cmp++; if (bcd4 !== 16'h2345) begin n_fail++; $display("[TB] FAIL ovf_12345_bcd: got %h expected 2345", bcd4); end
        n_cmp++; if (seg4 !== {4{DASH}}) begin n_fail++; $display("[TB] FAIL ovf_12345_seg: got %h expected %h", seg4, {4{DASH}}); end
        convert(1, 16'd9999, bc, ok);
        n_cmp++; if (ovf4 !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_9999_flag: got %b expected 0", ovf4); end
        n_cmp++; if (bcd4 !== 16'h9999) begin n_fail++; $display("[TB] FAIL ovf_9999_bcd: got %h expected 9999", bcd4); end
        n_cmp++; if (seg4 !== {4{S9}}) begin n_fail++; $display("[TB] FAIL ovf_9999_seg: got %h expected %h", seg4, {4{S9}}); end
        convert(1, 16'd10000, bc, ok);
        n_cmp++; if (ovf4 !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_10000_flag: got %b expected 1", ovf4); end
        n_cmp++; if (bcd4 !== 16'h0000) begin n_fail++; $display("[TB] FAIL ovf_10000_bcd: got %h expected 0000", bcd4); end
        n_cmp++; if (seg4 !== {4{DASH}}) begin n_fail++; $display("[TB] FAIL ovf_10000_seg: got %h expected %h", seg4, {4{DASH}}); end
    endtask

    task automatic test_active_low();
        int bc; bit ok;
        logic [34:0] exp_seg;
`ifdef BCD_SEG7_BLANK_ZERO_EN
        exp_seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
`else
        exp_seg = {7'h40, 7'h40, 7'h40, 7'h40, 7'h78};
`endif
        convert(2, 16'd7, bc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL al_done_seen: got %b expected 1", ok); end
        n_cmp++; if (bcd_al !== 20'h00007) begin n_fail++; $display("[TB] FAIL al_bcd: got %h expected 00007", bcd_al); end
        n_cmp++; if (seg_al !== exp_seg) begin n_fail++; $display("[TB] FAIL al_seg: got %h expected %h", seg_al, exp_seg); end
    endtask

    task automatic test_back_to_back();
        int c;
        bit seen;
        @(negedge clk);
        load0 = 1'b1;
        val0 = 16'd111;
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            val0 = val0 + 16'd7;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %b expected 1", seen); end
        n_cmp++; if (bcd0 !== 20'h00111) begin n_fail++; $display("[TB] FAIL b2b_first_bcd: got %h expected 00111", bcd0); end
        val0 = 16'd500;
        @(negedge clk);
        load0 = 1'b0;
        n_cmp++; if (busy0 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept_in_done: got %b expected 1", busy0); end
        n_cmp++; if (bcd0 !== 20'h00111) begin n_fail++; $display("[TB] FAIL b2b_hold_bcd: got %h expected 00111", bcd0); end
        c = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                seen = 1'b1;
                break;
            end
            c++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_second_done: got %b expected 1", seen); end
        n_cmp++; if (c != 16) begin n_fail++; $display("[TB] FAIL b2b_period: got %0d expected 16", c); end
        n_cmp++; if (bcd0 !== 20'h00500) begin n_fail++; $display("[TB] FAIL b2b_second_bcd: got %h expected 00500", bcd0); end
    endtask

    task automatic test_reset_mid();
        int bc; bit ok; bit seen;
        logic [34:0] exp_seg;
`ifdef BCD_SEG7_BLANK_ZERO_EN
        exp_seg = {BL, BL, BL, S4, S2};
`else
        exp_seg = {S0, S0, S0, S4, S2};
`endif
        @(negedge clk);
        load0 = 1'b1;
        val0 = 16'd9876;
        @(negedge clk);
        load0 = 1'b0;
        repeat (7) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy: got %b expected 0", busy0); end
        n_cmp++; if (seg0 !== 35'h0) begin n_fail++; $display("[TB] FAIL mid_seg: got %h expected 0", seg0); end
        n_cmp++; if (bcd0 !== 20'h0) begin n_fail++; $display("[TB] FAIL mid_bcd: got %h expected 00000", bcd0); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_no_done: got %b expected 0", seen); end
        convert(0, 16'd42, bc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_42_done: got %b expected 1", ok); end
        n_cmp++; if (bcd0 !== 20'h00042) begin n_fail++; $display("[TB] FAIL mid_42_bcd: got %h expected 00042", bcd0); end
        n_cmp++; if (seg0 !== exp_seg) begin n_fail++; $display("[TB] FAIL mid_42_seg: got %h expected %h", seg0, exp_seg); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_1234();
        test_max();
        test_zero();
        test_overflow();
        test_active_low();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
